// File: rtl/memory_param.sv
// memory_param: single-clock RAM with one write port and one registered read port.
// After reset, or on a clr pulse, an init sweep writes mem[i] = i+1 to every word.
// busy is high while the sweep runs.
// Optional even-parity storage and check, enabled by defining MEM_PARITY_EN.
module memory_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              par_inj,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] d_out,
    output logic              rd_valid,
    output logic              busy,
    output logic              parity_err
);

    localparam int DEPTH = 2 ** ADDR_W;
`ifdef MEM_PARITY_EN
    localparam int STORE_W = DATA_W + 1;
`else
    localparam int STORE_W = DATA_W;
`endif

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_idx;
    logic [ADDR_W-1:0]   w_idx_nxt;
    logic [ADDR_W:0]     w_idx_inc;

    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [DATA_W-1:0]   w_mem_data;
    logic                w_mem_inj;
    logic [STORE_W-1:0]  w_mem_word;
    logic                w_rd_fire;
    logic [STORE_W-1:0]  w_rd_word;

    logic [STORE_W-1:0]  r_mem [DEPTH];

    assign w_idx_inc = {1'b0, r_idx} + {{ADDR_W{1'b0}}, 1'b1};

    // FSM state and sweep index register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next state, sweep index, write-port mux and read qualification
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_mem_we    = 1'b0;
        w_mem_addr  = wr_addr;
        w_mem_data  = wr_data;
        w_mem_inj   = par_inj;
        w_rd_fire   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            ST_INIT: begin
                busy       = 1'b1;
                w_mem_we   = 1'b1;
                w_mem_addr = r_idx;
                w_mem_data = DATA_W'(w_idx_inc);
                w_mem_inj  = 1'b0;
                if (clr) begin
                    w_idx_nxt = '0;
                end else if (r_idx == '1) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_idx_nxt = w_idx_inc[ADDR_W-1:0];
                end
            end
            ST_RUN: begin
                if (clr) begin
                    w_state_nxt = ST_INIT;
                    w_idx_nxt   = '0;
                end else begin
                    w_mem_we  = wr_en;
                    w_rd_fire = rd_en;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
                w_idx_nxt   = '0;
            end
        endcase
    end

`ifdef MEM_PARITY_EN
    // Stored parity bit is even parity of the data, optionally inverted for fault injection
    assign w_mem_word = {(^w_mem_data) ^ w_mem_inj, w_mem_data};
`else
    logic w_unused_inj;
    assign w_unused_inj = w_mem_inj;
    assign w_mem_word   = w_mem_data;
`endif

    // Write-first: a same-address write in the read cycle bypasses the array
    assign w_rd_word = (wr_en && (wr_addr == rd_addr)) ? w_mem_word : r_mem[rd_addr];

    // Memory array write; contents are not reset, the sweep defines them
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_word;
        end
    end

    // Registered read data with one-cycle valid strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_out    <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= w_rd_fire;
            if (w_rd_fire) begin
                d_out <= w_rd_word[DATA_W-1:0];
            end
        end
    end

`ifdef MEM_PARITY_EN
    logic r_parity_err;

    // Parity check registered alongside d_out, cleared when no read fires
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_rd_fire && ((^w_rd_word[DATA_W-1:0]) != w_rd_word[DATA_W]);
        end
    end

    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

endmodule
